concat_packer: RTL and testbench
================================

# concat_packer

Parametrised sequential concatenation engine. Accepts IN_W-bit chunks over a valid/ready stream and packs NCHUNK of them MSB-first into one OUT_W-bit word, in the same way as the concatenation {c0, c1, ..., cN-1}. Supports early termination with zero padding and, optionally, replication fill. It sits between narrow field producers and wide-word consumers in the operator datapath.

## Interface
- IN_W, default 4: chunk width in bits, must be ≥1.
- NCHUNK, default 4: chunks per output word, must be ≥2.
- OUT_W, localparam, IN_W*NCHUNK: output word width.
- CNT_W, localparam, $clog2(NCHUNK+1): width of the chunk counter.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  a chunk is offered.
- in_ready  out  1  the packer can take a chunk this cycle.
- in_data  in  IN_W  chunk value.
- in_last  in  1  the chunk closes the current word early.
- repl  in  1  replicate in_data into all remaining slots. This port exists only when CONCAT_PACK_REPL_EN is defined.
- out_valid  out  1  a packed word is held.
- out_ready  in  1  the consumer accepts the word.
- out_data  out  OUT_W  packed word, left-justified.
- out_count  out  CNT_W  number of chunks received for this word, 1..NCHUNK.

## Operation
- States:
  - FILL: accumulating chunks.
  - HOLD: word presented on the output.
- Chunk k (0-based) is written to out_data[OUT_W-1-k*IN_W -: IN_W]. The first chunk lands in the MSBs.
- A chunk is accepted when in_valid && in_ready.
- FILL, on accept:
  - Store the chunk and increment the count.
  - Go to HOLD if the new count equals NCHUNK or in_last = 1.
  - Otherwise stay in FILL.
- Early close via in_last: slots not filled are 0. out_count equals the number of chunks received.
- HOLD:
  - out_valid = 1.
  - out_data and out_count are held stable until out_valid && out_ready.
- HOLD, on out_ready:
  - If a chunk is accepted in the same cycle, it becomes chunk 0 of a new word. The count becomes 1, and the next state is FILL, or HOLD if that chunk closes the word (in_last, or NCHUNK reached).
  - Otherwise the state returns to FILL, the count is cleared to 0, and out_data is cleared to 0.
- in_ready = (state==FILL) || (state==HOLD && out_ready). This is combinational from the state and out_ready, and gives full throughput.
- Replication (macro defined): a chunk accepted with repl = 1 at count k fills slots k..NCHUNK-1 with in_data. The count becomes NCHUNK and the state goes to HOLD. repl takes precedence over in_last.

## Timing
- Reset values:
  - State FILL.
  - out_valid 0.
  - out_data 0.
  - out_count 0.
  - in_ready 1.
- Latency: out_valid rises on the cycle after the edge that accepts the closing chunk.
- Throughput: one chunk per cycle sustained, including across word boundaries.
- out_valid never drops without out_ready. out_data never changes while out_valid && !out_ready.
- Reset asserted mid-word discards the partial word and any held word immediately, because the reset is asynchronous.
- in_last on the NCHUNK-th chunk behaves the same as a full word.

## Configuration
- CONCAT_PACK_REPL_EN:
  - Defined: the repl port is present and replication fill is active.
  - Undefined: the repl port is absent, and the packer only does plain concatenation with in_last padding.

## Structure
- Package concat_pack_pkg holds:
  - The state typedef (FILL, HOLD).
  - A helper function computing CNT_W.
- One sub-module, concat_chunk_insert. It is combinational and takes the current word, index, chunk and repl. It returns the next word, with the chunk written at the index slot, or written into all slots from the index onward when repl is set.

## Test plan
All scenarios use IN_W=4, NCHUNK=4.
- Plain pack: chunks 0xA, 0x5, 0x3, 0xC on back-to-back cycles with out_ready=1 → out_data=0xA53C and out_count=4, one cycle after the fourth accept.
- Early close: 0x7, then 0x1 with in_last=1 → out_data=0x7100, out_count=2.
- Backpressure: hold out_ready=0 for 3 cycles on word 0x1234 → out_data stays stable and in_ready=0. Then out_ready=1 with in_valid carrying 0x9 → the word hands off and 0x9 becomes the MSB chunk of the next word (count 1).
- Replication (macro defined):
  - repl with 0x6 at count 0 → out_data=0x6666.
  - 0x2, then repl with 0xF → out_data=0x2FFF, out_count=4.
- Reset mid-fill: assert rst_n=0 after 0xB, 0xE → all outputs return to 0 and in_ready=1. Then 0x1, 0x2, 0x3, 0x4 → out_data=0x1234.

Source files
------------

// File: rtl/concat_pack_pkg.sv
// Shared types and helpers for the concat_packer chunk-to-word packer.
// CONCAT_PACK_REPL_EN enables replication fill in the top module.
package concat_pack_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_e;

  // Counter must be able to hold NCHUNK itself, not just NCHUNK-1.
  function automatic int unsigned cnt_width(input int unsigned nchunk);
    return $clog2(nchunk + 1);
  endfunction

endpackage

// File: rtl/concat_chunk_insert.sv
// Writes one chunk into slot i_idx of a left-justified word, or into
// every slot from i_idx onward when i_repl is set.
module concat_chunk_insert
  import concat_pack_pkg::*;
#(
  parameter int unsigned IN_W   = 4,
  parameter int unsigned NCHUNK = 4,
  parameter int unsigned IDX_W  = 3,
  localparam int unsigned OUT_W = IN_W * NCHUNK
) (
  input  logic [OUT_W-1:0] i_word,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [IN_W-1:0]  i_chunk,
  input  logic             i_repl,
  output logic [OUT_W-1:0] o_word
);

  always_comb begin
    o_word = i_word;
    for (int k = 0; k < NCHUNK; k++) begin
      if ((IDX_W'(k) == i_idx) || (i_repl && (IDX_W'(k) > i_idx))) begin
        o_word[OUT_W-1-k*IN_W -: IN_W] = i_chunk;
      end
    end
  end

endmodule

// File: rtl/concat_packer.sv
// Packs NCHUNK IN_W-bit chunks MSB-first into one word over valid/ready.
// Define CONCAT_PACK_REPL_EN to add the repl port and replication fill.
module concat_packer
  import concat_pack_pkg::*;
#(
  parameter int unsigned IN_W   = 4,
  parameter int unsigned NCHUNK = 4,
  localparam int unsigned OUT_W = IN_W * NCHUNK,
  localparam int unsigned CNT_W = cnt_width(NCHUNK)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
`ifdef CONCAT_PACK_REPL_EN
  input  logic             repl,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count
);

  pack_state_e      r_state;
  pack_state_e      w_state_nxt;
  logic [OUT_W-1:0] r_data;
  logic [OUT_W-1:0] w_data_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_nxt;

  logic             w_accept;
  logic             w_repl;
  logic [OUT_W-1:0] w_base_word;
  logic [CNT_W-1:0] w_base_cnt;
  logic [CNT_W-1:0] w_inc;
  logic [OUT_W-1:0] w_ins_word;

`ifdef CONCAT_PACK_REPL_EN
  assign w_repl = repl;
`else
  assign w_repl = 1'b0;
`endif

  assign in_ready  = (r_state == FILL) || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == HOLD);
  assign out_data  = r_data;
  assign out_count = r_count;

  // A chunk accepted during hand-off starts a fresh word, so build on zero.
  assign w_base_word = (r_state == HOLD) ? '0 : r_data;
  assign w_base_cnt  = (r_state == HOLD) ? '0 : r_count;

  concat_chunk_insert #(
    .IN_W   (IN_W),
    .NCHUNK (NCHUNK),
    .IDX_W  (CNT_W)
  ) u_insert (
    .i_word  (w_base_word),
    .i_idx   (w_base_cnt),
    .i_chunk (in_data),
    .i_repl  (w_repl),
    .o_word  (w_ins_word)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_count_nxt = r_count;
    w_inc       = w_base_cnt + CNT_W'(1);
    if (w_accept) begin
      w_data_nxt  = w_ins_word;
      w_count_nxt = w_repl ? CNT_W'(NCHUNK) : w_inc;
      w_state_nxt = (w_repl || in_last || (w_inc == CNT_W'(NCHUNK))) ? HOLD : FILL;
    end else if ((r_state == HOLD) && out_ready) begin
      w_data_nxt  = '0;
      w_count_nxt = '0;
      w_state_nxt = FILL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FILL;
      r_data  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_count <= w_count_nxt;
    end
  end

endmodule

// File: tb/tb_concat_packer.sv
// Self-checking bench for concat_packer (IN_W=4, NCHUNK=4): table-driven words,
// scoreboard on output hand-offs, plus backpressure / reset / replication sequences.
module tb_concat_packer;

  localparam int unsigned IN_W   = 4;
  localparam int unsigned NCHUNK = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
  logic        in_last;
`ifdef CONCAT_PACK_REPL_EN
  logic        repl;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  out_count;

  concat_packer #(
    .IN_W   (IN_W),
    .NCHUNK (NCHUNK)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
`ifdef CONCAT_PACK_REPL_EN
    .repl      (repl),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct {
    logic [15:0] d;
    logic [2:0]  c;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    int          n;
    logic [3:0]  ch [4];
    logic        last;
    logic [15:0] exp_d;
    logic [2:0]  exp_c;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push_exp(input logic [15:0] d, input logic [2:0] c);
    exp_t e;
    e.d = d;
    e.c = c;
    exp_q.push_back(e);
  endtask

  // Offer one chunk and return #1 after the edge that accepts it.
  task automatic send(input logic [3:0] d, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
`ifdef CONCAT_PACK_REPL_EN
    repl     = 1'b0;
`endif
  endtask

  // Scoreboard and hold-stability monitor, sampled on the falling edge.
  logic        prev_hold;
  logic [15:0] prev_d;
  logic [2:0]  prev_c;
  initial begin
    exp_t e;
    prev_hold = 1'b0;
    prev_d    = '0;
    prev_c    = '0;
    forever begin
      @(negedge clk);
      if (prev_hold && rst_n) begin
        chk("hold_valid", {31'd0, out_valid}, 32'd1);
        chk("hold_data", {16'd0, out_data}, {16'd0, prev_d});
        chk("hold_count", {29'd0, out_count}, {29'd0, prev_c});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", {16'd0, out_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("word_data", {16'd0, out_data}, {16'd0, e.d});
          chk("word_count", {29'd0, out_count}, {29'd0, e.c});
        end
      end
      prev_hold = out_valid && !out_ready && rst_n;
      prev_d    = out_data;
      prev_c    = out_count;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic drain_check(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(name, exp_q.size(), 32'd0);
  endtask

  initial begin
    vecs[0] = '{n: 4, ch: '{4'hA, 4'h5, 4'h3, 4'hC}, last: 1'b0, exp_d: 16'hA53C, exp_c: 3'd4};
    vecs[1] = '{n: 2, ch: '{4'h7, 4'h1, 4'h0, 4'h0}, last: 1'b1, exp_d: 16'h7100, exp_c: 3'd2};
    vecs[2] = '{n: 1, ch: '{4'hF, 4'h0, 4'h0, 4'h0}, last: 1'b1, exp_d: 16'hF000, exp_c: 3'd1};
    vecs[3] = '{n: 4, ch: '{4'h1, 4'h2, 4'h3, 4'h4}, last: 1'b1, exp_d: 16'h1234, exp_c: 3'd4};
    vecs[4] = '{n: 3, ch: '{4'h8, 4'h0, 4'h9, 4'h0}, last: 1'b1, exp_d: 16'h8090, exp_c: 3'd3};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
`ifdef CONCAT_PACK_REPL_EN
    repl      = 1'b0;
`endif
    #12;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {16'd0, out_data}, 32'd0);
    chk("rst_count", {29'd0, out_count}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Table words, back-to-back across word boundaries.
    for (int v = 0; v < 5; v++) begin
      for (int k = 0; k < vecs[v].n; k++) begin
        if (k == vecs[v].n - 1) push_exp(vecs[v].exp_d, vecs[v].exp_c);
        send(vecs[v].ch[k], (k == vecs[v].n - 1) ? vecs[v].last : 1'b0);
        if (v == 0 && k == 3) chk("latency_valid", {31'd0, out_valid}, 32'd1);
      end
    end
    drain_check("table_drain");

    // Backpressure: word held while out_ready is low.
    out_ready = 1'b0;
    send(4'h1, 1'b0);
    send(4'h2, 1'b0);
    send(4'h3, 1'b0);
    push_exp(16'h1234, 3'd4);
    send(4'h4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_data", {16'd0, out_data}, 32'h1234);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(4'h9, 1'b0);
    chk("handoff_valid", {31'd0, out_valid}, 32'd0);
    chk("handoff_count", {29'd0, out_count}, 32'd1);
    chk("handoff_data", {16'd0, out_data}, 32'h9000);
    push_exp(16'h9800, 3'd2);
    send(4'h8, 1'b1);
    drain_check("bp_drain");

    // Reset mid-fill discards the partial word.
    send(4'hB, 1'b0);
    send(4'hE, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_data", {16'd0, out_data}, 32'd0);
    chk("midrst_count", {29'd0, out_count}, 32'd0);
    chk("midrst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(4'h1, 1'b0);
    send(4'h2, 1'b0);
    send(4'h3, 1'b0);
    push_exp(16'h1234, 3'd4);
    send(4'h4, 1'b0);
    drain_check("rst_drain");

`ifdef CONCAT_PACK_REPL_EN
    push_exp(16'h6666, 3'd4);
    repl = 1'b1;
    send(4'h6, 1'b0);
    send(4'h2, 1'b0);
    push_exp(16'h2FFF, 3'd4);
    repl = 1'b1;
    send(4'hF, 1'b0);
    send(4'h3, 1'b0);
    push_exp(16'h3AAA, 3'd4);
    repl = 1'b1;
    send(4'hA, 1'b1);
    drain_check("repl_drain");
`endif

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
